e203_irq_inject_sched: RTL and testbench

Synthesizable interrupt and bus-error injection scheduler for the E203 subsystem stress environment. It watches the commit-stage PC stream and, once the program has left its reset vector, runs three independent interrupt channels (external, software, timer) and one ITCM read-bus-error channel. Each channel uses its own LFSR to pick random delays, asserts its line, and waits for the matching handler PC before re-arming. It sits beside `e203_subsys_main` and drives `plic_ext_irq`, `clint_sft_irq`, `clint_tmr_irq` and the ITCM `sram_icb_rsp_err` gate. Injection stops after a programmable number of tohost writes.

---
 rtl/e203_irq_inject_sched.sv | 209 ++++++++++++++++++++
 tb/tb_e203_irq_inject_sched.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/e203_irq_inject_sched.sv
// Interrupt and ITCM bus-error injection scheduler for the E203 stress environment.
// Three LFSR-timed irq channels plus one bus-error window generator, armed by the start PC.
module e203_irq_inject_sched #(
    parameter logic [31:0] PC_START   = 32'h8000015C,
    parameter logic [31:0] PC_TOHOST  = 32'h80000086,
    parameter logic [31:0] PC_EXT_ACK = 32'h800000a6,
    parameter logic [31:0] PC_SFT_ACK = 32'h800000be,
    parameter logic [31:0] PC_TMR_ACK = 32'h800000d6,
    parameter int unsigned DLY_W      = 10,
    parameter int unsigned ERR_LO_W   = 4,
    parameter int unsigned ERR_HI_W   = 8,
    parameter logic [31:0] STOP_CNT   = 32'd32,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        cmt_valid,
    input  logic [31:0] cmt_pc,
    input  logic        status_mie,
    input  logic        itcm_rsp_read,
    output logic        ext_irq,
    output logic        sft_irq,
    output logic        tmr_irq,
    output logic        itcm_bus_err,
    output logic [31:0] tohost_cnt,
    output logic        done,
    output logic        irq_quiet
);

    localparam int unsigned CNT_W  = DLY_W + 1;
    localparam int unsigned ECNT_W = ((ERR_HI_W > ERR_LO_W) ? ERR_HI_W : ERR_LO_W) + 1;
    localparam logic [3:0][15:0] SEEDS = {SEED ^ 16'h3C3C, SEED ^ 16'hA5A5, SEED ^ 16'h5A5A, SEED};

    typedef enum logic [1:0] {I_ARM, I_DELAY, I_ASSERT, I_DONE} irq_st_e;
    typedef enum logic [1:0] {E_ARM, E_LO, E_HI, E_DONE} err_st_e;

    logic            start_hit;
    logic            tohost_hit;
    logic [2:0]      ack_hit;
    logic            stop;
    logic [3:0][15:0] lfsr_q;
    logic [2:0]      irq_q;
    logic [2:0]      irq_nxt;
    logic [2:0]      irq_done_nxt;
    logic            err_raw_q;

    assign start_hit  = cmt_valid & (cmt_pc == PC_START);
    assign tohost_hit = cmt_valid & (cmt_pc == PC_TOHOST);
    assign ack_hit[0] = cmt_valid & (cmt_pc == PC_EXT_ACK);
    assign ack_hit[1] = cmt_valid & (cmt_pc == PC_SFT_ACK);
    assign ack_hit[2] = cmt_valid & (cmt_pc == PC_TMR_ACK);
    assign stop       = (tohost_cnt > STOP_CNT);

    // Saturating tohost commit counter, independent of en.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tohost_cnt <= '0;
        end else if (tohost_hit && (tohost_cnt != '1)) begin
            tohost_cnt <= tohost_cnt + 32'd1;
        end
    end

    // Four Fibonacci LFSRs, x^16+x^14+x^13+x^11+1; zero seeds are replaced by 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                lfsr_q[k] <= (SEEDS[k] == 16'h0000) ? 16'h0001 : SEEDS[k];
            end
        end else if (en) begin
            for (int k = 0; k < 4; k++) begin
                lfsr_q[k] <= {lfsr_q[k][14:0],
                              lfsr_q[k][15] ^ lfsr_q[k][13] ^ lfsr_q[k][12] ^ lfsr_q[k][10]};
            end
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_irq
        irq_st_e          st_q, st_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] dly;
        logic             line_q;

        assign dly = CNT_W'(lfsr_q[g][DLY_W-1:0]) + CNT_W'(1);

        always_comb begin
            st_d  = st_q;
            cnt_d = cnt_q;
            if (!en) begin
                st_d = I_ARM;
            end else begin
                case (st_q)
                    I_ARM: begin
                        if (start_hit) begin
                            st_d  = I_DELAY;
                            cnt_d = dly;
                        end
                    end
                    I_DELAY: begin
                        if (cnt_q == CNT_W'(1)) begin
                            st_d = I_ASSERT;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                    I_ASSERT: begin
                        if (ack_hit[g]) begin
                            if (stop) begin
                                st_d = I_DONE;
                            end else begin
                                st_d  = I_DELAY;
                                cnt_d = dly;
                            end
                        end
                    end
                    I_DONE:  st_d = I_DONE;
                    default: st_d = I_ARM;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                st_q   <= I_ARM;
                cnt_q  <= '0;
                line_q <= 1'b0;
            end else begin
                st_q   <= st_d;
                cnt_q  <= cnt_d;
                line_q <= (st_d == I_ASSERT);
            end
        end

        assign irq_q[g]        = line_q;
        assign irq_nxt[g]      = (st_d == I_ASSERT);
        assign irq_done_nxt[g] = (st_d == I_DONE);
    end

    err_st_e           est_q, est_d;
    logic [ECNT_W-1:0] ecnt_q, ecnt_d;
    logic [ECNT_W-1:0] lo_len, hi_len;

    assign lo_len = ECNT_W'(lfsr_q[3][ERR_LO_W-1:0]) + ECNT_W'(1);
    assign hi_len = ECNT_W'(lfsr_q[3][ERR_HI_W-1:0]) + ECNT_W'(1);

    // Bus-error window generator: alternating LO/HI windows of random length.
    always_comb begin
        est_d  = est_q;
        ecnt_d = ecnt_q;
        if (!en) begin
            est_d = E_ARM;
        end else begin
            case (est_q)
                E_ARM: begin
                    if (start_hit) begin
                        est_d  = E_LO;
                        ecnt_d = lo_len;
                    end
                end
                E_LO: begin
                    if (ecnt_q == ECNT_W'(1)) begin
                        est_d  = E_HI;
                        ecnt_d = hi_len;
                    end else begin
                        ecnt_d = ecnt_q - ECNT_W'(1);
                    end
                end
                E_HI: begin
                    if (ecnt_q == ECNT_W'(1)) begin
                        if (stop) begin
                            est_d = E_DONE;
                        end else begin
                            est_d  = E_LO;
                            ecnt_d = lo_len;
                        end
                    end else begin
                        ecnt_d = ecnt_q - ECNT_W'(1);
                    end
                end
                E_DONE:  est_d = E_DONE;
                default: est_d = E_ARM;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            est_q     <= E_ARM;
            ecnt_q    <= '0;
            err_raw_q <= 1'b0;
            done      <= 1'b0;
            irq_quiet <= 1'b1;
        end else begin
            est_q     <= est_d;
            ecnt_q    <= ecnt_d;
            err_raw_q <= (est_d == E_HI);
            done      <= (&irq_done_nxt) & (est_d == E_DONE);
            irq_quiet <= ~(|irq_nxt);
        end
    end

    assign ext_irq = irq_q[0];
    assign sft_irq = irq_q[1];
    assign tmr_irq = irq_q[2];

    // Only read responses while interrupts are enabled (non-handler code) get corrupted.
    assign itcm_bus_err = err_raw_q & status_mie & itcm_rsp_read;

endmodule

// File: tb/tb_e203_irq_inject_sched.sv
// Self-checking bench for e203_irq_inject_sched: hand-derived vector table,
// timestamp-based reference model under random commit streams, and directed corner cases.
module tb_e203_irq_inject_sched;

    localparam logic [31:0] PC_START   = 32'h8000015C;
    localparam logic [31:0] PC_TOHOST  = 32'h80000086;
    localparam logic [31:0] PC_EXT_ACK = 32'h800000a6;
    localparam logic [31:0] PC_SFT_ACK = 32'h800000be;
    localparam logic [31:0] PC_TMR_ACK = 32'h800000d6;
    localparam int unsigned DLY_W      = 1;
    localparam int unsigned ERR_LO_W   = 2;
    localparam int unsigned ERR_HI_W   = 3;
    localparam logic [31:0] STOP_CNT   = 32'd2;
    localparam logic [15:0] SEED       = 16'hACE1;

    localparam logic [15:0] DMASK  = 16'((32'd1 << DLY_W) - 32'd1);
    localparam logic [15:0] LOMASK = 16'((32'd1 << ERR_LO_W) - 32'd1);
    localparam logic [15:0] HIMASK = 16'((32'd1 << ERR_HI_W) - 32'd1);

    logic        clk, rst_n, en, cmt_valid, status_mie, itcm_rsp_read;
    logic [31:0] cmt_pc;
    logic        ext_irq, sft_irq, tmr_irq, itcm_bus_err, done, irq_quiet;
    logic [31:0] tohost_cnt;

    e203_irq_inject_sched #(
        .PC_START(PC_START), .PC_TOHOST(PC_TOHOST), .PC_EXT_ACK(PC_EXT_ACK),
        .PC_SFT_ACK(PC_SFT_ACK), .PC_TMR_ACK(PC_TMR_ACK), .DLY_W(DLY_W),
        .ERR_LO_W(ERR_LO_W), .ERR_HI_W(ERR_HI_W), .STOP_CNT(STOP_CNT), .SEED(SEED)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .cmt_valid(cmt_valid), .cmt_pc(cmt_pc),
        .status_mie(status_mie), .itcm_rsp_read(itcm_rsp_read),
        .ext_irq(ext_irq), .sft_irq(sft_irq), .tmr_irq(tmr_irq),
        .itcm_bus_err(itcm_bus_err), .tohost_cnt(tohost_cnt), .done(done),
        .irq_quiet(irq_quiet)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: each channel is a pending rise time, not a state machine.
    int          cyc;
    logic [15:0] m_lfsr [4];
    bit          m_wait [3];
    int          m_rise [3];
    bit          m_done [3];
    bit          e_act, e_done;
    int          e_hs, e_he;
    logic [31:0] m_cnt;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [31:0] ack_pc(input int c);
        case (c)
            0:       return PC_EXT_ACK;
            1:       return PC_SFT_ACK;
            default: return PC_TMR_ACK;
        endcase
    endfunction

    function automatic bit m_line(input int c);
        return m_wait[c] && (cyc >= m_rise[c]);
    endfunction

    function automatic bit m_err();
        return e_act && (cyc >= e_hs) && (cyc <= e_he);
    endfunction

    function automatic logic dut_line(input int c);
        case (c)
            0:       return ext_irq;
            1:       return sft_irq;
            default: return tmr_irq;
        endcase
    endfunction

    task automatic model_reset();
        m_lfsr[0] = SEED;
        m_lfsr[1] = SEED ^ 16'h5A5A;
        m_lfsr[2] = SEED ^ 16'hA5A5;
        m_lfsr[3] = SEED ^ 16'h3C3C;
        for (int c = 0; c < 3; c++) begin
            m_wait[c] = 1'b0; m_done[c] = 1'b0; m_rise[c] = 0;
        end
        e_act = 1'b0; e_done = 1'b0; e_hs = 0; e_he = -1;
        m_cnt = '0;
    endtask

    // Advance the model across the coming clock edge using the current inputs.
    task automatic model_step();
        int  t;
        bit  stop, hit_start;
        t = cyc;
        if (!rst_n) begin
            model_reset();
        end else begin
            stop      = (m_cnt > STOP_CNT);
            hit_start = cmt_valid && (cmt_pc == PC_START);
            if (cmt_valid && (cmt_pc == PC_TOHOST) && (m_cnt != 32'hFFFF_FFFF)) m_cnt = m_cnt + 1;
            if (!en) begin
                for (int c = 0; c < 3; c++) begin m_wait[c] = 1'b0; m_done[c] = 1'b0; end
                e_act = 1'b0; e_done = 1'b0;
            end else begin
                for (int c = 0; c < 3; c++) begin
                    if (!m_wait[c] && !m_done[c]) begin
                        if (hit_start) begin
                            m_wait[c] = 1'b1;
                            m_rise[c] = t + 2 + int'(m_lfsr[c] & DMASK);
                        end
                    end else if (m_line(c) && cmt_valid && (cmt_pc == ack_pc(c))) begin
                        if (stop) begin
                            m_wait[c] = 1'b0; m_done[c] = 1'b1;
                        end else begin
                            m_rise[c] = t + 2 + int'(m_lfsr[c] & DMASK);
                        end
                    end
                end
                if (!e_act && !e_done) begin
                    if (hit_start) begin
                        e_act = 1'b1; e_he = -1;
                        e_hs  = t + 2 + int'(m_lfsr[3] & LOMASK);
                    end
                end else if (e_act) begin
                    if (t == e_he) begin
                        if (stop) begin
                            e_act = 1'b0; e_done = 1'b1;
                        end else begin
                            e_hs = t + 2 + int'(m_lfsr[3] & LOMASK);
                        end
                    end else if (t == e_hs - 1) begin
                        e_he = e_hs + int'(m_lfsr[3] & HIMASK);
                    end
                end
                for (int k = 0; k < 4; k++) m_lfsr[k] = lfsr_next(m_lfsr[k]);
            end
        end
        cyc = cyc + 1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
        end
    endtask

    task automatic check_all();
        chk("ext_irq", 32'(ext_irq), 32'(m_line(0)));
        chk("sft_irq", 32'(sft_irq), 32'(m_line(1)));
        chk("tmr_irq", 32'(tmr_irq), 32'(m_line(2)));
        chk("itcm_bus_err", 32'(itcm_bus_err), 32'(m_err() & status_mie & itcm_rsp_read));
        chk("tohost_cnt", tohost_cnt, m_cnt);
        chk("done", 32'(done), 32'(m_done[0] & m_done[1] & m_done[2] & e_done));
        chk("irq_quiet", 32'(irq_quiet), 32'(!(m_line(0) | m_line(1) | m_line(2))));
    endtask

    task automatic step(input bit do_check);
        model_step();
        @(posedge clk);
        #1;
        if (do_check) check_all();
    endtask

    task automatic drive(input logic v, input logic [31:0] pc);
        cmt_valid = v;
        cmt_pc    = pc;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        drive(1'b0, 32'h0);
        repeat (n) step(1'b0);
        rst_n = 1'b1;
    endtask

    task automatic wait_line(input int c, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (dut_line(c) === 1'b1) begin ok = 1'b1; break; end
            step(1'b1);
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: line %0d still low after 64 cycles, required high", name, c);
        end
    endtask

    task automatic rand_cycle(input bit allow_tohost, input bit allow_en_drop);
        int r;
        r = int'($urandom_range(0, 99));
        en            = allow_en_drop ? ($urandom_range(0, 49) != 0) : 1'b1;
        cmt_valid     = ($urandom_range(0, 3) != 0);
        status_mie    = 1'($urandom_range(0, 1));
        itcm_rsp_read = 1'($urandom_range(0, 1));
        if (r < 4)                       cmt_pc = PC_START;
        else if (r < 8 && allow_tohost)  cmt_pc = PC_TOHOST;
        else if (r < 22)                 cmt_pc = PC_EXT_ACK;
        else if (r < 36)                 cmt_pc = PC_SFT_ACK;
        else if (r < 50)                 cmt_pc = PC_TMR_ACK;
        else                             cmt_pc = $urandom();
        step(1'b1);
    endtask

    typedef struct {
        logic        en;
        logic        valid;
        logic [31:0] pc;
        logic        ext;
        logic        sft;
        logic        tmr;
        logic        quiet;
    } vec_t;

    vec_t tbl [7];

    initial begin
        bit ok;
        // Cycle 0 is the first cycle after reset; outputs are those of the following cycle.
        tbl[0] = '{1'b1, 1'b1, PC_START,   1'b0, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{1'b1, 1'b1, PC_SFT_ACK, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 32'h0,      1'b1, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b1, PC_EXT_ACK, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 32'h0,      1'b0, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 32'h0,      1'b1, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{1'b1, 1'b1, PC_TMR_ACK, 1'b1, 1'b1, 1'b0, 1'b0};

        cyc = 0;
        model_reset();
        rst_n = 1'b0; en = 1'b0; status_mie = 1'b0; itcm_rsp_read = 1'b0;
        drive(1'b0, 32'h0);
        #1;

        // Reset values, then idle with no commits.
        do_reset(5);
        chk("rst_ext", 32'(ext_irq), 32'd0);
        chk("rst_sft", 32'(sft_irq), 32'd0);
        chk("rst_tmr", 32'(tmr_irq), 32'd0);
        chk("rst_cnt", tohost_cnt, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_quiet", 32'(irq_quiet), 32'd1);
        en = 1'b1;
        repeat (20) step(1'b1);
        chk("idle_lines", {29'd0, ext_irq, sft_irq, tmr_irq}, 32'd0);

        // Hand-derived vectors from the seed LFSR values.
        do_reset(1);
        for (int i = 0; i < 7; i++) begin
            en = tbl[i].en;
            drive(tbl[i].valid, tbl[i].pc);
            step(1'b0);
            chk($sformatf("tbl%0d_ext", i),   32'(ext_irq),   32'(tbl[i].ext));
            chk($sformatf("tbl%0d_sft", i),   32'(sft_irq),   32'(tbl[i].sft));
            chk($sformatf("tbl%0d_tmr", i),   32'(tmr_irq),   32'(tbl[i].tmr));
            chk($sformatf("tbl%0d_quiet", i), 32'(irq_quiet), 32'(tbl[i].quiet));
        end

        // Random commit streams with en drops, no tohost.
        do_reset(1);
        repeat (1500) rand_cycle(1'b0, 1'b1);

        // Random commit streams with tohost hits reaching the stop condition.
        repeat (8) begin
            do_reset(1);
            repeat (250) rand_cycle(1'b1, 1'b0);
        end

        // Stop after ACK.
        en = 1'b1; status_mie = 1'b0; itcm_rsp_read = 1'b1;
        do_reset(1);
        drive(1'b1, PC_START); step(1'b1);
        repeat (3) begin drive(1'b1, PC_TOHOST); step(1'b1); end
        chk("stop_cnt", tohost_cnt, 32'd3);
        drive(1'b0, 32'h0);
        for (int c = 0; c < 3; c++) begin
            wait_line(c, "stop_wait");
            drive(1'b1, ack_pc(c)); step(1'b1);
            chk($sformatf("stop_ack%0d", c), 32'(dut_line(c)), 32'd0);
            drive(1'b0, 32'h0);
        end
        repeat (5) step(1'b1);
        chk("stop_lines", {29'd0, ext_irq, sft_irq, tmr_irq}, 32'd0);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done === 1'b1) begin ok = 1'b1; break; end
            step(1'b1);
        end
        chk("stop_done", 32'(ok), 32'd1);
        drive(1'b1, PC_START); step(1'b1);
        drive(1'b0, 32'h0);
        repeat (6) step(1'b1);
        chk("done_no_rearm", {29'd0, ext_irq, sft_irq, tmr_irq}, 32'd0);
        chk("done_held", 32'(done), 32'd1);

        // Bus-error gating inside one HI cycle.
        status_mie = 1'b0; itcm_rsp_read = 1'b1;
        do_reset(1);
        drive(1'b1, PC_START); step(1'b1);
        drive(1'b0, 32'h0);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (m_err()) begin ok = 1'b1; break; end
            step(1'b1);
        end
        chk("err_hi_reached", 32'(ok), 32'd1);
        #1 chk("err_mie0", 32'(itcm_bus_err), 32'd0);
        status_mie = 1'b1;
        #1 chk("err_on", 32'(itcm_bus_err), 32'd1);
        itcm_rsp_read = 1'b0;
        #1 chk("err_rd0", 32'(itcm_bus_err), 32'd0);
        status_mie = 1'b0;

        // Mid-operation reset while tmr_irq is high.
        do_reset(1);
        drive(1'b1, PC_START);  step(1'b1);
        drive(1'b1, PC_TOHOST); step(1'b1);
        drive(1'b0, 32'h0);
        wait_line(2, "midrst_wait");
        chk("midrst_pre_cnt", tohost_cnt, 32'd1);
        rst_n = 1'b0; step(1'b1); rst_n = 1'b1;
        chk("midrst_tmr", 32'(tmr_irq), 32'd0);
        chk("midrst_cnt", tohost_cnt, 32'd0);

        // en low while asserted, then re-arm on the next start hit.
        drive(1'b1, PC_START); step(1'b1);
        drive(1'b0, 32'h0);
        wait_line(0, "en_wait");
        en = 1'b0; step(1'b1);
        chk("en_low_ext", 32'(ext_irq), 32'd0);
        en = 1'b1;
        repeat (4) step(1'b1);
        chk("en_armed_ext", 32'(ext_irq), 32'd0);
        drive(1'b1, PC_START); step(1'b1);
        drive(1'b0, 32'h0);
        wait_line(0, "en_rearm");
        chk("en_rearm_ext", 32'(ext_irq), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
